// File: rtl/uart_bridge_pkg.sv
// Shared types and byte codes for the UART-to-bus debug bridge.
// The CHK state exists only when UART_BRIDGE_CHECKSUM_EN is defined.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
        CHK,
`endif
        BUS_WR,
        BUS_RD,
        SEND
    } bridge_state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_ERR   = 8'h45;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART byte stream and CPU data bus signals seen by the bridge.
// master = bridge side, slave = UART/bus side.
interface uart_bus_bridge_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_we_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_rdata_i;
    logic        bus_busy_o;
    logic        overrun_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, bus_rdata_i,
        output tx_data_o, tx_valid_o, bus_addr_o, bus_wdata_o,
               bus_we_o, bus_wstrb_o, bus_busy_o, overrun_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, bus_rdata_i,
        input  tx_data_o, tx_valid_o, bus_addr_o, bus_wdata_o,
               bus_we_o, bus_wstrb_o, bus_busy_o, overrun_o
    );
endinterface

// File: rtl/bridge_shift32.sv
// 32-bit MSB-first byte shift-in register with a 2-bit byte counter.
// done is high on the load that completes the fourth byte.
module bridge_shift32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] value,
    output logic        done
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= 32'h0;
            cnt   <= 2'd0;
        end else if (load) begin
            value <= {value[23:0], byte_in};
            cnt   <= cnt + 2'd1;
        end
    end

    assign done = load && (cnt == 2'd3);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART byte-command to 32-bit bus initiator ('W' write, 'R' read).
// Define UART_BRIDGE_CHECKSUM_EN to require an XOR checksum byte on writes.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    uart_bus_bridge_if.master br
);

    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RD_LAST  = 16'(READ_LATENCY);

    bridge_state_e state_q, state_d;

    logic        sr_clr, addr_ld, data_ld, addr_done, data_done;
    logic        rsp_ld;
    logic [7:0]  rsp_byte;
    logic [31:0] tx_buf;
    logic [1:0]  tx_cnt;
    logic [15:0] rd_cnt;
    logic [31:0] to_cnt;
    logic        is_write;
    logic        overrun_q;
    logic        rx_state, busy_state, rd_last, timeout;
`ifdef UART_BRIDGE_CHECKSUM_EN
    logic [7:0]  chk_acc;
`endif

    bridge_shift32 u_addr (
        .clk(clk), .reset(reset), .clr(sr_clr), .load(addr_ld),
        .byte_in(br.rx_data_i), .value(br.bus_addr_o), .done(addr_done)
    );

    bridge_shift32 u_data (
        .clk(clk), .reset(reset), .clr(sr_clr), .load(data_ld),
        .byte_in(br.rx_data_i), .value(br.bus_wdata_o), .done(data_done)
    );

`ifdef UART_BRIDGE_CHECKSUM_EN
    assign rx_state = (state_q == ADDR) || (state_q == DATA) || (state_q == CHK);
`else
    assign rx_state = (state_q == ADDR) || (state_q == DATA);
`endif
    assign busy_state = (state_q == BUS_WR) || (state_q == BUS_RD) || (state_q == SEND);
    assign rd_last    = (rd_cnt == RD_LAST);
    assign timeout    = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST) && !br.rx_valid_i;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        sr_clr   = 1'b0;
        addr_ld  = 1'b0;
        data_ld  = 1'b0;
        rsp_ld   = 1'b0;
        rsp_byte = RSP_ACK;
        case (state_q)
            IDLE: begin
                if (br.rx_valid_i) begin
                    sr_clr = 1'b1;
                    if (br.rx_data_i == CMD_WRITE || br.rx_data_i == CMD_READ) begin
                        state_d = ADDR;
                    end else begin
                        state_d  = SEND;
                        rsp_ld   = 1'b1;
                        rsp_byte = RSP_BAD;
                    end
                end
            end
            ADDR: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (br.rx_valid_i) begin
                    addr_ld = 1'b1;
                    if (addr_done) state_d = is_write ? DATA : BUS_RD;
                end
            end
            DATA: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (br.rx_valid_i) begin
                    data_ld = 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    if (data_done) state_d = CHK;
`else
                    if (data_done) state_d = BUS_WR;
`endif
                end
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            CHK: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (br.rx_valid_i) begin
                    if (br.rx_data_i == chk_acc) begin
                        state_d = BUS_WR;
                    end else begin
                        state_d  = SEND;
                        rsp_ld   = 1'b1;
                        rsp_byte = RSP_ERR;
                    end
                end
            end
`endif
            BUS_WR: begin
                state_d = SEND;
                rsp_ld  = 1'b1;
            end
            BUS_RD: begin
                if (rd_last) state_d = SEND;
            end
            SEND: begin
                if (br.tx_ready_i && tx_cnt == 2'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_buf    <= 32'h0;
            tx_cnt    <= 2'd0;
            rd_cnt    <= 16'd0;
            to_cnt    <= 32'd0;
            is_write  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= br.rx_valid_i && busy_state;

            // Single-byte responses sit in the top byte; reads load all four.
            if (rsp_ld) begin
                tx_buf <= {rsp_byte, 24'h0};
                tx_cnt <= 2'd0;
            end else if (state_q == BUS_RD && rd_last) begin
                tx_buf <= br.bus_rdata_i;
                tx_cnt <= 2'd3;
            end else if (state_q == SEND && br.tx_ready_i) begin
                tx_buf <= {tx_buf[23:0], 8'h0};
                tx_cnt <= tx_cnt - 2'd1;
            end

            rd_cnt <= (state_q == BUS_RD) ? rd_cnt + 16'd1 : 16'd0;
            to_cnt <= (rx_state && !br.rx_valid_i) ? to_cnt + 32'd1 : 32'd0;

            if (state_q == IDLE && br.rx_valid_i) is_write <= (br.rx_data_i == CMD_WRITE);
        end
    end

`ifdef UART_BRIDGE_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)                                  chk_acc <= 8'h0;
        else if (state_q == IDLE && br.rx_valid_i)  chk_acc <= br.rx_data_i;
        else if (rx_state && br.rx_valid_i)         chk_acc <= chk_acc ^ br.rx_data_i;
    end
`endif

    assign br.tx_valid_o  = (state_q == SEND);
    assign br.tx_data_o   = tx_buf[31:24];
    assign br.bus_we_o    = (state_q == BUS_WR);
    assign br.bus_wstrb_o = (state_q == BUS_WR) ? 4'hF : 4'h0;
    assign br.bus_busy_o  = (state_q != IDLE);
    assign br.overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge (READ_LATENCY=1, TIMEOUT_CYCLES=16).
// Honors UART_BRIDGE_CHECKSUM_EN for the checksum write scenarios.
module tb_uart_bus_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    uart_bus_bridge_if bif ();

    uart_bus_bridge #(.READ_LATENCY(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .br(bif)
    );

    always #50 clk = ~clk;

    // One-cycle BRAM model with two preloaded words.
    always @(posedge clk) begin
        if (bif.bus_addr_o == 32'h00040010)      bif.bus_rdata_i <= 32'h12345678;
        else if (bif.bus_addr_o == 32'h00002000) bif.bus_rdata_i <= 32'hCAFEF00D;
        else                                     bif.bus_rdata_i <= 32'h0;
    end

    logic [7:0]  txq[$];
    int          we_cnt = 0;
    int          ovr_cnt = 0;
    logic [31:0] we_addr, we_data;
    logic [3:0]  we_strb;

    always @(posedge clk) begin
        if (!reset && bif.tx_valid_o && bif.tx_ready_i) txq.push_back(bif.tx_data_o);
        if (bif.bus_we_o) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bif.bus_addr_o;
            we_data <= bif.bus_wdata_o;
            we_strb <= bif.bus_wstrb_o;
        end
        if (bif.overrun_o) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bif.rx_data_i  = b;
        bif.rx_valid_i = 1'b1;
        @(negedge clk);
        bif.rx_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 8;
        if (bif.tx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %0h want 0", bif.tx_valid_o); end
        if (bif.tx_data_o !== 8'h0) begin errors++; $display("FAIL rst_tx_data got %0h want 0", bif.tx_data_o); end
        if (bif.bus_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %0h want 0", bif.bus_we_o); end
        if (bif.bus_wstrb_o !== 4'h0) begin errors++; $display("FAIL rst_wstrb got %0h want 0", bif.bus_wstrb_o); end
        if (bif.bus_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %0h want 0", bif.bus_addr_o); end
        if (bif.bus_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata got %0h want 0", bif.bus_wdata_o); end
        if (bif.bus_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", bif.bus_busy_o); end
        if (bif.overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0h want 0", bif.overrun_o); end
    endtask

    task automatic test_write;
        logic [7:0] cmd[$];
        int we0;
        cmd = '{8'h57, 8'h00, 8'h04, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef UART_BRIDGE_CHECKSUM_EN
        cmd.push_back(8'h61);
`endif
        txq.delete();
        we0 = we_cnt;
        send_byte(cmd[0]);
        checks++;
        if (bif.bus_busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy_rise got %0h want 1", bif.bus_busy_o); end
        for (int i = 1; i < cmd.size(); i++) send_byte(cmd[i]);
        for (int i = 0; i < 50 && txq.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        checks += 6;
        if (txq.size() != 1 || txq[0] !== 8'h4B) begin errors++; $display("FAIL wr_ack got n=%0d b=%0h want n=1 b=4b", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx); end
        if (we_cnt - we0 != 1) begin errors++; $display("FAIL wr_we_cycles got %0d want 1", we_cnt - we0); end
        if (we_addr !== 32'h00040010) begin errors++; $display("FAIL wr_addr got %0h want 00040010", we_addr); end
        if (we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got %0h want deadbeef", we_data); end
        if (we_strb !== 4'hF) begin errors++; $display("FAIL wr_strb got %0h want f", we_strb); end
        if (bif.bus_busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %0h want 0", bif.bus_busy_o); end
    endtask

    task automatic test_read_stall;
        logic [7:0] exp[4];
        exp = '{8'h12, 8'h34, 8'h56, 8'h78};
        txq.delete();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 50 && txq.size() < 1; i++) @(negedge clk);
        bif.tx_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bif.tx_valid_o !== 1'b1 || bif.tx_data_o !== 8'h34) begin
                errors++; $display("FAIL rd_stall_hold got v=%0h d=%0h want v=1 d=34", bif.tx_valid_o, bif.tx_data_o);
            end
            @(negedge clk);
        end
        bif.tx_ready_i = 1'b1;
        for (int i = 0; i < 50 && txq.size() < 4; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (txq.size() != 4) begin errors++; $display("FAIL rd_count got %0d want 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp[i]) begin errors++; $display("FAIL rd_byte%0d got %0h want %0h", i, txq[i], exp[i]); end
        end
        checks++;
        if (bif.bus_busy_o !== 1'b0) begin errors++; $display("FAIL rd_busy_end got %0h want 0", bif.bus_busy_o); end
    endtask

    task automatic test_bad_cmd;
        int we0;
        txq.delete();
        we0 = we_cnt;
        send_byte(8'h41);
        for (int i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        checks += 3;
        if (txq.size() != 1 || txq[0] !== 8'h3F) begin errors++; $display("FAIL bad_rsp got n=%0d b=%0h want n=1 b=3f", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx); end
        if (we_cnt != we0) begin errors++; $display("FAIL bad_no_write got %0d want 0", we_cnt - we0); end
        if (bif.bus_busy_o !== 1'b0) begin errors++; $display("FAIL bad_busy_end got %0h want 0", bif.bus_busy_o); end
    endtask

    task automatic test_timeout;
        logic [7:0] exp[4];
        int we0;
        exp = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        txq.delete();
        we0 = we_cnt;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h04);
        repeat (10) @(negedge clk);
        checks++;
        if (bif.bus_busy_o !== 1'b1) begin errors++; $display("FAIL to_busy_mid got %0h want 1", bif.bus_busy_o); end
        repeat (10) @(negedge clk);
        checks += 3;
        if (bif.bus_busy_o !== 1'b0) begin errors++; $display("FAIL to_idle got %0h want 0", bif.bus_busy_o); end
        if (txq.size() != 0) begin errors++; $display("FAIL to_no_rsp got %0d want 0", txq.size()); end
        if (we_cnt != we0) begin errors++; $display("FAIL to_no_write got %0d want 0", we_cnt - we0); end
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        for (int i = 0; i < 50 && txq.size() < 4; i++) @(negedge clk);
        checks++;
        if (txq.size() != 4) begin errors++; $display("FAIL to_next_count got %0d want 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp[i]) begin errors++; $display("FAIL to_next_byte%0d got %0h want %0h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_overrun;
        int ov0;
        txq.delete();
        ov0 = ovr_cnt;
        bif.tx_ready_i = 1'b0;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 20 && !bif.tx_valid_o; i++) @(negedge clk);
        send_byte(8'h55);
        repeat (3) @(negedge clk);
        checks += 2;
        if (ovr_cnt - ov0 != 1) begin errors++; $display("FAIL ovr_pulse got %0d want 1", ovr_cnt - ov0); end
        if (bif.tx_valid_o !== 1'b1 || bif.tx_data_o !== 8'h12) begin
            errors++; $display("FAIL ovr_tx_hold got v=%0h d=%0h want v=1 d=12", bif.tx_valid_o, bif.tx_data_o);
        end
        bif.tx_ready_i = 1'b1;
        for (int i = 0; i < 50 && txq.size() < 4; i++) @(negedge clk);
        checks++;
        if (txq.size() != 4 || txq[0] !== 8'h12 || txq[3] !== 8'h78) begin
            errors++; $display("FAIL ovr_rsp got n=%0d want 4 bytes 12..78", txq.size());
        end
    endtask

    task automatic test_reset_mid;
        txq.delete();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h10);
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bif.bus_busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy got %0h want 0", bif.bus_busy_o); end
        if (bif.bus_addr_o !== 32'h0) begin errors++; $display("FAIL mid_addr got %0h want 0", bif.bus_addr_o); end
        if (bif.tx_valid_o !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got %0h want 0", bif.tx_valid_o); end
        if (bif.tx_data_o !== 8'h0) begin errors++; $display("FAIL mid_tx_data got %0h want 0", bif.tx_data_o); end
        if (bif.bus_we_o !== 1'b0 || bif.bus_wstrb_o !== 4'h0) begin errors++; $display("FAIL mid_we got %0h/%0h want 0/0", bif.bus_we_o, bif.bus_wstrb_o); end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (txq.size() != 0) begin errors++; $display("FAIL mid_abandon got %0d bytes want 0", txq.size()); end
    endtask

`ifdef UART_BRIDGE_CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] cmd[9];
        int we0;
        cmd = '{8'h57, 8'h00, 8'h00, 8'h20, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0F};
        txq.delete();
        we0 = we_cnt;
        for (int i = 0; i < 9; i++) send_byte(cmd[i]);
        send_byte(8'h7C);
        for (int i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
        checks += 3;
        if (txq.size() != 1 || txq[0] !== 8'h4B) begin errors++; $display("FAIL chk_ok_rsp got n=%0d want 4b", txq.size()); end
        if (we_cnt - we0 != 1) begin errors++; $display("FAIL chk_ok_we got %0d want 1", we_cnt - we0); end
        if (we_addr !== 32'h00002004 || we_data !== 32'h0000000F) begin errors++; $display("FAIL chk_ok_bus got %0h/%0h want 00002004/0000000f", we_addr, we_data); end
        txq.delete();
        we0 = we_cnt;
        for (int i = 0; i < 9; i++) send_byte(cmd[i]);
        send_byte(8'h00);
        for (int i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks += 2;
        if (txq.size() != 1 || txq[0] !== 8'h45) begin errors++; $display("FAIL chk_bad_rsp got n=%0d want 45", txq.size()); end
        if (we_cnt != we0) begin errors++; $display("FAIL chk_bad_we got %0d want 0", we_cnt - we0); end
    endtask
`endif

    initial begin
        bif.rx_data_i  = 8'h0;
        bif.rx_valid_i = 1'b0;
        bif.tx_ready_i = 1'b1;
        test_reset();
        test_write();
        test_read_stall();
        test_bad_cmd();
        test_timeout();
        test_overrun();
        test_reset_mid();
`ifdef UART_BRIDGE_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
